// File: rtl/spi_regfile_peripheral.sv
// ============================================================================
// spi_regfile_peripheral
//
// SPI mode-0 (CPOL=0, CPHA=0) target that decodes 1+ADDR_W+DATA_W bit frames
// {rw, addr, data} (MSB first, rw=1 means write) into NUM_REGS registers.
// SCLK, nCS and COPI are oversampled in the clk domain through SYNC_STAGES
// synchroniser flops and edge-detected after the last stage.
//
// Optional feature macro: SPI_READBACK_EN
//   defined   : read frames (rw=0) shift reg[addr] out on cipo during the
//               data phase (0 for out-of-range addresses)
//   undefined : cipo tied low; read frames are parsed and length-checked only
//
// Ports
//   clk        system clock, at least 8x the SCLK frequency
//   rst_n      asynchronous active-low reset
//   ncs        SPI chip select, active low
//   sclk       SPI clock
//   copi       controller-out data
//   cipo       target-out data (read data)
//   regs_out   register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse   one-hot, high for one clk when reg k is written
//   frame_err  one clk pulse when a frame has the wrong length
// ============================================================================
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ncs,
    input  logic                         sclk,
    input  logic                         copi,
    output logic                         cipo,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic                         frame_err
);

    localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    // Shift register must hold the whole header as well as the data field.
    localparam int SHIFT_W    = ((1 + ADDR_W) > DATA_W) ? (1 + ADDR_W) : DATA_W;

    localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVR      = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        COMMIT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] copi_sync;
    logic                   ncs_d;
    logic                   sclk_d;
    logic [CNT_W-1:0]       cnt;
    logic [SHIFT_W-1:0]     shift_q;
    logic [SHIFT_W-1:0]     shift_next;
    logic                   rw_q;
    logic [ADDR_W-1:0]      addr_q;

    logic ncs_s;
    logic sclk_s;
    logic copi_s;
    logic start;
    logic stop;
    logic sclk_rise;
    logic hdr_done;

    // Synchronisers idle at the bus-idle levels so that reset release with
    // the bus idle produces no spurious edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync  <= '1;
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_d     <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign ncs_s      = ncs_sync[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign copi_s     = copi_sync[SYNC_STAGES-1];
    assign start      = ncs_d & ~ncs_s;
    assign stop       = ~ncs_d & ncs_s;
    assign sclk_rise  = ~ncs_s & sclk_s & ~sclk_d;
    assign shift_next = {shift_q[SHIFT_W-2:0], copi_s};
    // Rise that completes the rw+address header.
    assign hdr_done   = (state == ADDR) && sclk_rise && (cnt == CNT_HDR_LAST);

    // Frame FSM, register file and registered strobes. A stop in any state
    // goes to COMMIT, where the frame length decides between write and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            regs_out  <= '0;
            wr_pulse  <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_pulse  <= '0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (stop) begin
                        state <= COMMIT;
                    end else if (start) begin
                        state   <= ADDR;
                        cnt     <= '0;
                        shift_q <= '0;
                    end
                end
                ADDR: begin
                    if (stop) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        cnt     <= cnt + 1'b1;
                        shift_q <= shift_next;
                        if (hdr_done) begin
                            rw_q   <= shift_next[ADDR_W];
                            addr_q <= shift_next[ADDR_W-1:0];
                            state  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (stop) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        // Extra bits park the counter at FRAME_BITS+1 so an
                        // overrun can never wrap back to a valid length.
                        if (cnt < CNT_FRAME) begin
                            cnt     <= cnt + 1'b1;
                            shift_q <= shift_next;
                        end else begin
                            cnt <= CNT_OVR;
                        end
                    end
                end
                COMMIT: begin
                    if (cnt == CNT_FRAME) begin
                        // Out-of-range addresses match no k and are dropped.
                        if (rw_q) begin
                            for (int k = 0; k < NUM_REGS; k++) begin
                                if (addr_q == ADDR_W'(k)) begin
                                    regs_out[k*DATA_W +: DATA_W] <= shift_q[DATA_W-1:0];
                                    wr_pulse[k]                  <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                    cnt     <= '0;
                    shift_q <= '0;
                    // A start arriving while committing begins the next frame.
                    state   <= start ? ADDR : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rd_word;
    logic              sclk_fall;

    assign sclk_fall = ~ncs_s & ~sclk_s & sclk_d;

    // Read mux keyed by the address being latched this cycle.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (shift_next[ADDR_W-1:0] == ADDR_W'(k)) begin
                rd_word = regs_out[k*DATA_W +: DATA_W];
            end
        end
    end

    // The fall right after the last header rise must not shift: the MSB is
    // presented then and sampled by the controller on the next rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else if (state == IDLE) begin
            tx_q <= '0;
        end else if (hdr_done && !shift_next[ADDR_W]) begin
            tx_q <= rd_word;
        end else if ((state == DATA) && sclk_fall && (cnt > CNT_W'(1 + ADDR_W))) begin
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo = tx_q[DATA_W-1];
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// ============================================================================
// tb_spi_regfile_peripheral
//
// Directed bench for spi_regfile_peripheral: acts as an SPI mode-0 controller,
// drives hand-built frames and compares registers, strobe counts and read data
// against hand-computed values. Read-data checks follow SPI_READBACK_EN.
// ============================================================================
module tb_spi_regfile_peripheral;

    localparam int HALF = 5;   // clk cycles per SCLK half period

`ifdef SPI_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ncs;
    logic        sclk;
    logic        copi;
    logic        cipo;
    logic [39:0] regs_out;
    logic [4:0]  wr_pulse;
    logic        frame_err;

    int          check_count;
    int          error_count;
    int          wr_cycles [5];
    int          err_cycles;
    logic [4:0]  last_pulse;
    logic [7:0]  rx_byte;
    logic [39:0] exp_regs;

    spi_regfile_peripheral dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ncs       (ncs),
        .sclk      (sclk),
        .copi      (copi),
        .cipo      (cipo),
        .regs_out  (regs_out),
        .wr_pulse  (wr_pulse),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles so one-clk pulse widths and counts can be checked.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (wr_pulse[k]) wr_cycles[k]++;
        end
        if (wr_pulse != 5'b0) last_pulse = wr_pulse;
        if (frame_err) err_cycles++;
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int totalWrites();
        int s = 0;
        for (int k = 0; k < 5; k++) s += wr_cycles[k];
        return s;
    endfunction

    // One SPI bit: set data while SCLK is low, sample cipo just before the rise.
    task automatic sendBit(input logic b, input bit capture);
        copi = b;
        waitClk(HALF);
        if (capture) rx_byte = {rx_byte[6:0], cipo};
        sclk = 1'b1;
        waitClk(HALF);
        sclk = 1'b0;
    endtask

    // Send nbits of frame MSB first, then hold ncs high for gap clk cycles.
    task automatic applyStimulus(input logic [31:0] frame, input int nbits, input int gap);
        rx_byte = 8'h00;
        ncs = 1'b0;
        waitClk(HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            sendBit(frame[i], (nbits - 1 - i) >= 8);
        end
        waitClk(HALF);
        ncs = 1'b1;
        waitClk(gap);
    endtask

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_count = 0;
        error_count = 0;
        err_cycles  = 0;
        last_pulse  = '0;
        rx_byte     = '0;
        exp_regs    = '0;
        for (int k = 0; k < 5; k++) wr_cycles[k] = 0;

        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        copi  = 1'b0;
        waitClk(4);
        rst_n = 1'b1;
        waitClk(4);

        $display("[TB] reset state");
        checkOutput("reset_regs", 64'(regs_out), 64'h0);
        checkOutput("reset_wr_pulse", 64'(wr_pulse), 64'h0);
        checkOutput("reset_frame_err", 64'(frame_err), 64'h0);
        checkOutput("reset_cipo", 64'(cipo), 64'h0);

        $display("[TB] single write reg2=A5");
        applyStimulus(32'h82A5, 16, 10);
        exp_regs[2*8 +: 8] = 8'hA5;
        checkOutput("wr2_regs", 64'(regs_out), 64'(exp_regs));
        checkOutput("wr2_pulse_value", 64'(last_pulse), 64'h04);
        checkOutput("wr2_pulse_cycles", 64'(wr_cycles[2]), 64'd1);
        checkOutput("wr2_total_pulses", 64'(totalWrites()), 64'd1);
        checkOutput("wr2_no_err", 64'(err_cycles), 64'd0);

        $display("[TB] back-to-back writes reg4=3C, reg0=FF");
        applyStimulus(32'h843C, 16, 4);
        applyStimulus(32'h80FF, 16, 10);
        exp_regs[4*8 +: 8] = 8'h3C;
        exp_regs[0*8 +: 8] = 8'hFF;
        checkOutput("b2b_regs", 64'(regs_out), 64'(exp_regs));
        checkOutput("b2b_pulse_reg4", 64'(wr_cycles[4]), 64'd1);
        checkOutput("b2b_pulse_reg0", 64'(wr_cycles[0]), 64'd1);
        checkOutput("b2b_total_pulses", 64'(totalWrites()), 64'd3);

        $display("[TB] out-of-range write addr 5");
        applyStimulus(32'h8511, 16, 10);
        checkOutput("oor_regs", 64'(regs_out), 64'(exp_regs));
        checkOutput("oor_total_pulses", 64'(totalWrites()), 64'd3);
        checkOutput("oor_no_err", 64'(err_cycles), 64'd0);

        $display("[TB] short and overrun frames");
        applyStimulus(32'h082A, 12, 10);
        checkOutput("short_err", 64'(err_cycles), 64'd1);
        applyStimulus(32'h10267, 17, 10);
        checkOutput("overrun_err", 64'(err_cycles), 64'd2);
        checkOutput("badlen_regs", 64'(regs_out), 64'(exp_regs));
        checkOutput("badlen_total_pulses", 64'(totalWrites()), 64'd3);

        $display("[TB] read frames");
        applyStimulus(32'h0200, 16, 10);
        checkOutput("read2_data", 64'(rx_byte), RB_EN ? 64'hA5 : 64'h00);
        checkOutput("read2_regs", 64'(regs_out), 64'(exp_regs));
        applyStimulus(32'h7F00, 16, 10);
        checkOutput("read7f_data", 64'(rx_byte), 64'h00);
        checkOutput("read_no_err", 64'(err_cycles), 64'd2);
        checkOutput("read_total_pulses", 64'(totalWrites()), 64'd3);
        checkOutput("idle_cipo", 64'(cipo), 64'h0);

        $display("[TB] reset during write to reg1");
        rx_byte = 8'h00;
        ncs = 1'b0;
        waitClk(HALF);
        for (int i = 15; i >= 6; i--) begin
            sendBit(logic'((16'h81C3 >> i) & 16'h1), 1'b0);
        end
        rst_n = 1'b0;
        waitClk(3);
        ncs  = 1'b1;
        sclk = 1'b0;
        waitClk(3);
        rst_n = 1'b1;
        waitClk(10);
        exp_regs = '0;
        checkOutput("midrst_regs", 64'(regs_out), 64'h0);
        checkOutput("midrst_total_pulses", 64'(totalWrites()), 64'd3);

        applyStimulus(32'h815A, 16, 10);
        exp_regs[1*8 +: 8] = 8'h5A;
        checkOutput("after_rst_regs", 64'(regs_out), 64'(exp_regs));
        checkOutput("after_rst_pulse_reg1", 64'(wr_cycles[1]), 64'd1);
        checkOutput("after_rst_pulse_value", 64'(last_pulse), 64'h02);
        checkOutput("final_err", 64'(err_cycles), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
